// File: rtl/capture_pkg.sv
// Shared definitions for the APB pixel capture block: register map, bit
// positions, FSM encoding and the default FIFO depth.
package capture_pkg;

   localparam int FIFO_DEPTH_DEFAULT = 512;
   localparam int WORDS_W            = 20;

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h04;
   localparam logic [7:0] ADDR_DATA   = 8'h08;
   localparam logic [7:0] ADDR_WORDS  = 8'h0C;

   localparam int CTRL_ARM     = 0;
   localparam int CTRL_FLUSH   = 1;
   localparam int CTRL_DONE_IE = 2;
   localparam int CTRL_OVF_IE  = 3;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_OVF     = 2;
   localparam int STAT_LVL_LSB = 16;
   localparam int STAT_LVL_MSB = 25;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_VS    = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_CAPTURE    = 3'd3,
      ST_DONE       = 3'd4
   } cap_state_e;

endpackage

// File: rtl/capture_fifo.sv
// Single-clock first-word-fall-through FIFO with a level output; the storage
// array has no reset so it maps onto fabric RAM.
module capture_fifo #(
   parameter int DEPTH = 512,
   parameter int WIDTH = 32,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [LW-1:0]    level,
   output logic             empty,
   output logic             push_ok
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             full;
   logic             pop_ok;

   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty;
   // A full FIFO still accepts a push when a pop frees the head slot this cycle.
   assign push_ok = push & ~flush & (~full | pop_ok);
   assign rdata   = mem[rd_ptr];
   assign level   = count;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pixel_capture_apb.sv
// Camera frame grabber: waits for a clean frame start, packs 8-bit pixels into
// 32-bit words, buffers them in a FIFO and exposes control/data over APB3.
module pixel_capture_apb
   import capture_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
   parameter int PIX_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] cam_pix,
   input  logic             cam_pix_vld,
   input  logic             cam_href,
   input  logic             cam_vsync,
   input  logic             PSEL,
   input  logic             PENABLE,
   input  logic             PWRITE,
   input  logic [7:0]       PADDR,
   input  logic [31:0]      PWDATA,
   output logic [31:0]      PRDATA,
   output logic             PREADY,
   output logic             PSLVERR,
   output logic             irq
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   cap_state_e         state;
   cap_state_e         state_nx;
   logic               vsync_q;
   logic               vsync_rise;
   logic               vsync_fall;

   logic               wr_acc;
   logic               rd_acc;
   logic               ctrl_wr;
   logic               status_wr;
   logic               arm_req;
   logic               flush_req;
   logic               arm_ok;
   logic               data_rd;

   logic               done_ie;
   logic               ovf_ie;
   logic               done;
   logic               ovf;
   logic [WORDS_W-1:0] words;
   logic               busy;

   logic [1:0]         pack_idx;
   logic [31:0]        pack_word;
   logic               push_pending;
   logic [31:0]        push_word;

   logic [31:0]        fifo_rdata;
   logic [LW-1:0]      fifo_level;
   logic               fifo_empty;
   logic               push_ok;
   logic [9:0]         status_level;
   logic [31:0]        prdata;
   logic               unused_pwdata;

   assign wr_acc     = PSEL & PENABLE & PWRITE;
   assign rd_acc     = PSEL & PENABLE & ~PWRITE;
   assign ctrl_wr    = wr_acc & (PADDR == ADDR_CTRL);
   assign status_wr  = wr_acc & (PADDR == ADDR_STATUS);
   assign arm_req    = ctrl_wr & PWDATA[CTRL_ARM];
   assign flush_req  = ctrl_wr & PWDATA[CTRL_FLUSH];
   assign arm_ok     = arm_req & ~flush_req & (state == ST_IDLE);
   assign data_rd    = rd_acc & (PADDR == ADDR_DATA);
   assign vsync_rise = ~vsync_q & cam_vsync;
   assign vsync_fall = vsync_q & ~cam_vsync;
   assign busy       = (state == ST_WAIT_VS) || (state == ST_WAIT_START) ||
                       (state == ST_CAPTURE);
   assign unused_pwdata = ^PWDATA[31:4];

   capture_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush_req),
      .push    (push_pending),
      .pop     (data_rd),
      .wdata   (push_word),
      .rdata   (fifo_rdata),
      .level   (fifo_level),
      .empty   (fifo_empty),
      .push_ok (push_ok)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         vsync_q <= 1'b0;
      end else begin
         state   <= state_nx;
         vsync_q <= cam_vsync;
      end
   end

   // Only a falling vsync seen after a high level starts capture, so arming
   // mid-frame always skips the remainder of that frame.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:       if (arm_ok)     state_nx = ST_WAIT_VS;
         ST_WAIT_VS:    if (cam_vsync)  state_nx = ST_WAIT_START;
         ST_WAIT_START: if (vsync_fall) state_nx = ST_CAPTURE;
         ST_CAPTURE:    if (vsync_rise) state_nx = ST_DONE;
         ST_DONE:                       state_nx = ST_IDLE;
         default:                       state_nx = ST_IDLE;
      endcase
      if (flush_req) begin
         state_nx = ST_IDLE;
      end
   end

   // The push register gives the one-cycle delay between a completed word and
   // the FIFO write, and keeps bytes of the word under construction separate.
   always_ff @(posedge clk) begin
      if (rst || flush_req) begin
         pack_idx     <= 2'd0;
         pack_word    <= '0;
         push_pending <= 1'b0;
         push_word    <= '0;
      end else begin
         push_pending <= 1'b0;
         if (state != ST_CAPTURE) begin
            pack_idx  <= 2'd0;
            pack_word <= '0;
         end else if (cam_pix_vld) begin
            if (cam_href) begin
               if (pack_idx == 2'd3) begin
                  push_pending <= 1'b1;
                  push_word    <= {cam_pix, pack_word[23:0]};
                  pack_word    <= '0;
                  pack_idx     <= 2'd0;
               end else begin
                  pack_word[{pack_idx, 3'b000} +: 8] <= cam_pix;
                  pack_idx <= pack_idx + 2'd1;
               end
            end else if (pack_idx != 2'd0) begin
               push_pending <= 1'b1;
               push_word    <= pack_word;
               pack_word    <= '0;
               pack_idx     <= 2'd0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_ie <= 1'b0;
         ovf_ie  <= 1'b0;
         done    <= 1'b0;
         ovf     <= 1'b0;
         words   <= '0;
      end else begin
         if (ctrl_wr) begin
            done_ie <= PWDATA[CTRL_DONE_IE];
            ovf_ie  <= PWDATA[CTRL_OVF_IE];
         end
         if (flush_req) begin
            done <= 1'b0;
            ovf  <= 1'b0;
         end else begin
            done <= (done & ~(status_wr & PWDATA[STAT_DONE])) | (state == ST_DONE);
            ovf  <= (ovf & ~(status_wr & PWDATA[STAT_OVF])) | (push_pending & ~push_ok);
         end
         if (arm_ok) begin
            words <= '0;
         end else if (push_ok && (words != {WORDS_W{1'b1}})) begin
            words <= words + WORDS_W'(1);
         end
      end
   end

   assign status_level = 10'(fifo_level);

   always_comb begin
      prdata = '0;
      if (PSEL && !PWRITE) begin
         case (PADDR)
            ADDR_CTRL: begin
               prdata[CTRL_DONE_IE] = done_ie;
               prdata[CTRL_OVF_IE]  = ovf_ie;
            end
            ADDR_STATUS: begin
               prdata[STAT_BUSY]                 = busy;
               prdata[STAT_DONE]                 = done;
               prdata[STAT_OVF]                  = ovf;
               prdata[STAT_LVL_MSB:STAT_LVL_LSB] = status_level;
            end
            ADDR_DATA:  prdata = fifo_empty ? 32'h0 : fifo_rdata;
            ADDR_WORDS: prdata = {{(32 - WORDS_W){1'b0}}, words};
            default:    prdata = '0;
         endcase
      end
   end

   assign PRDATA  = prdata;
   assign PREADY  = 1'b1;
   assign PSLVERR = data_rd & fifo_empty;
   assign irq     = (done & done_ie) | (ovf & ovf_ie);

endmodule

// File: doc/pixel_capture_apb.md
PIXEL_CAPTURE_APB -- requirements
Module: pixel_capture_apb

Interface
REQ-001 Parameter FIFO_DEPTH, default 512: number of 32-bit words in the capture FIFO; must be a power of two.
REQ-002 Parameter PIX_W, default 8: camera pixel width in bits; fixed at 8 in this revision.
REQ-003 clk  in  1  single fabric clock (MSS FAB_CLK); all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cam_pix  in  8  pixel byte, already synchronised to clk.
REQ-006 cam_pix_vld  in  1  one-cycle strobe marking a new cam_pix sample.
REQ-007 cam_href  in  1  line valid, sampled only on cam_pix_vld cycles.
REQ-008 cam_vsync  in  1  frame sync, active-high, already synchronised.
REQ-009 PSEL, PENABLE, PWRITE  in  1 each  APB3 slave control from MSS fabric interface.
REQ-010 PADDR  in  8  byte address; PWDATA  in  32  write data.
REQ-011 PRDATA  out  32;  PREADY  out  1;  PSLVERR  out  1.
REQ-012 irq  out  1  level interrupt to MSS: done or overflow, gated by CTRL enables.

Function
REQ-013 Register map: 0x00 CTRL (RW: b0 ARM self-clearing, b1 FLUSH self-clearing, b2 DONE_IE, b3 OVF_IE); 0x04 STATUS (RO: b0 busy, b1 done, b2 overflow, b[25:16] FIFO word level); 0x08 DATA (RO, pop); 0x0C WORDS (RO, words written this frame, 20 bits); writing 1 to STATUS b1/b2 clears that flag.
REQ-014 PREADY SHALL be constant 1; PRDATA SHALL be valid in the access phase (combinational from registers/FIFO head); unmapped addresses read 0, writes ignored, PSLVERR=0.
REQ-015 DATA read with FIFO empty SHALL return 0 with PSLVERR=1 and no pop; non-empty DATA read returns head word and pops exactly once per access phase.
REQ-016 FSM states IDLE, WAIT_VS, WAIT_START, CAPTURE, DONE.
REQ-017 IDLE -> WAIT_VS on ARM; ARM in any other state ignored.
REQ-018 WAIT_VS -> WAIT_START when cam_vsync is 1; WAIT_START -> CAPTURE on cam_vsync falling edge (frame start); partial frames never captured.
REQ-019 CAPTURE -> DONE on next cam_vsync rising edge; DONE sets STATUS.done and returns to IDLE the following cycle; busy=1 in WAIT_VS, WAIT_START, CAPTURE.
REQ-020 In CAPTURE, each cam_pix_vld with cam_href=1 SHALL pack the byte into a word, first pixel at [7:0], fourth at [31:24]; the fourth pixel pushes the word one cycle later.
REQ-021 On cam_href falling (sampled at cam_pix_vld) with 1-3 bytes pending, the partial word SHALL be pushed zero-padded in upper bytes; packer index resets per line.
REQ-022 Push when full SHALL be dropped and set STATUS.overflow, unless a pop occurs the same cycle, in which case push is accepted.
REQ-023 Simultaneous push and pop with FIFO non-full and non-empty SHALL leave level unchanged.
REQ-024 WORDS SHALL count accepted pushes, clear on ARM, saturate at 2^20-1.
REQ-025 FLUSH SHALL empty FIFO, clear packer, overflow and done, force IDLE in the cycle after the write; FLUSH with ARM in same write: FLUSH wins.
REQ-026 irq = (done & DONE_IE) | (overflow & OVF_IE).

Reset
REQ-027 rst SHALL, at the next clk edge, force IDLE, empty FIFO, clear packer, CTRL=0, done=0, overflow=0, WORDS=0; outputs after reset: PRDATA=0 (no access), PSLVERR=0, PREADY=1, irq=0.
REQ-028 rst mid-frame SHALL discard all captured data; no partial word pushed.

Structure
REQ-029 Shared package capture_pkg holds register offsets, CTRL/STATUS bit indices, FSM state encoding, FIFO_DEPTH default.
REQ-030 FIFO SHALL be sub-module capture_fifo (single-clock, first-word-fall-through, level output, inferable as fabric RAM); packer, FSM and APB decode stay in the top.

Verification
REQ-031 ARM, frame of 2 lines x 8 pixels 0x00..0x0F -> WORDS=4, DATA reads 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, done=1.
REQ-032 Line of 6 pixels 0xA1..0xA6 -> words 0xA4A3A2A1, 0x0000A6A5.
REQ-033 ARM while vsync low mid-frame -> no capture until next full frame; WORDS=0 during remainder.
REQ-034 FIFO_DEPTH=512, 2100 pixels, no reads -> level=512, overflow=1, irq=1 with OVF_IE=1; DATA read on empty after draining -> 0, PSLVERR=1.
REQ-035 rst asserted after 5 pixels of a line -> level=0, busy=0, next DATA read PSLVERR=1.
REQ-036 FIFO full, APB pop coinciding with push -> level stays 512, overflow stays 0.
